// File: rtl/ahb_rr_grant_ctrl.sv
// Registered round-robin bus-ownership controller for the shared AHB master
// port. Grants one master at a time, hands the bus over only on transfer
// boundaries, and bounds each tenure with a quantum unless the owner is
// performing a locked sequence. A single dead cycle separates owners.
module ahb_rr_grant_ctrl #(
  parameter int NM      = 8,
  parameter int MW      = 3,
  parameter int QUANTUM = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [NM-1:0] HBUSREQ,
  input  logic [NM-1:0] HLOCK,
  input  logic [1:0]    HTRANS,
  input  logic          HREADY,
  output logic [NM-1:0] HGRANT,
  output logic [MW-1:0] HMASTER,
  output logic          HMASTLOCK,
  output logic          BUS_IDLE
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Quantum fits in 8 bits (1..255); the counter saturates at this value.
  localparam logic [7:0] QUANT = 8'(QUANTUM);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t        state;
  logic [MW-1:0] last;
  logic [7:0]    cnt;

  logic [MW-1:0] sel;
  logic [NM-1:0] owner_mask;
  logic          owner_req;
  logic          owner_lock;
  logic          others_req;
  logic          quantum_up;
  logic          release_req;
  logic          boundary;

  // First requesting master found searching circularly from ptr+1.
  function automatic logic [MW-1:0] rr_pick(input logic [NM-1:0] req,
                                            input logic [MW-1:0] ptr);
    logic [MW-1:0] pick;
    logic [MW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = MW'((int'(ptr) + k) % NM);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // One-hot decode of a master index.
  function automatic logic [NM-1:0] onehot(input logic [MW-1:0] i);
    logic [NM-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Arbitration choice and release/boundary decode for the current owner.
  always_comb begin
    sel         = rr_pick(HBUSREQ, last);
    owner_mask  = onehot(HMASTER);
    owner_req   = HBUSREQ[HMASTER];
    owner_lock  = HLOCK[HMASTER] & owner_req;
    others_req  = |(HBUSREQ & ~owner_mask);
    quantum_up  = (cnt >= QUANT);
    // A lock only protects the tenure while the owner still requests.
    release_req = !owner_req || (quantum_up && others_req && !owner_lock);
    boundary    = HREADY && ((HTRANS == TRANS_IDLE) || (HTRANS == TRANS_NONSEQ));
  end

  // Ownership FSM with all bus-facing outputs registered.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HGRANT    <= '0;
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
      BUS_IDLE  <= 1'b1;
      last      <= MW'(NM - 1);
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // HMASTER keeps the previous owner so its data phase completes.
          if (|HBUSREQ) begin
            state     <= ST_OWN;
            HGRANT    <= onehot(sel);
            HMASTER   <= sel;
            last      <= sel;
            cnt       <= '0;
            HMASTLOCK <= HLOCK[sel] & HBUSREQ[sel];
            BUS_IDLE  <= 1'b0;
          end
        end
        ST_OWN: begin
          if (release_req && boundary) begin
            // Dead cycle follows; the pointer already names this owner, so
            // it drops to lowest priority in the next arbitration.
            state     <= ST_IDLE;
            HGRANT    <= '0;
            HMASTLOCK <= 1'b0;
            BUS_IDLE  <= 1'b1;
            cnt       <= '0;
          end else begin
            HMASTLOCK <= owner_lock;
            if (HREADY && (cnt < QUANT)) begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          HGRANT    <= '0;
          HMASTLOCK <= 1'b0;
          BUS_IDLE  <= 1'b1;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rr_grant_ctrl.sv
// Scoreboard bench for ahb_rr_grant_ctrl (QUANTUM=4). Each stimulus step
// pushes the hand-computed outputs expected after the next rising edge; a
// monitor pops and compares them, and checks the grant invariants each cycle.
module tb_ahb_rr_grant_ctrl;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [7:0] HBUSREQ = '0;
  logic [7:0] HLOCK = '0;
  logic [1:0] HTRANS = NS;
  logic       HREADY = 1'b1;
  logic [7:0] HGRANT;
  logic [2:0] HMASTER;
  logic       HMASTLOCK;
  logic       BUS_IDLE;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] master;
    logic       mlock;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  ahb_rr_grant_ctrl #(.NM(8), .MW(3), .QUANTUM(4)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK),
    .BUS_IDLE  (BUS_IDLE)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic [7:0] req, input logic [7:0] lock, input logic [1:0] tr,
                      input logic rdy, input logic [7:0] g, input logic [2:0] m,
                      input logic ml);
    @(negedge HCLK);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = tr;
    HREADY  = rdy;
    exp_q.push_back('{grant: g, master: m, mlock: ml});
  endtask

  // Unlocked, NONSEQ, HREADY=1 cycle.
  task automatic st(input logic [7:0] req, input logic [7:0] g, input logic [2:0] m);
    step(req, 8'h00, NS, 1'b1, g, m, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, HGRANT, 8'h00);
    check({tag, "_master"}, HMASTER, 3'd0);
    check({tag, "_mastlock"}, HMASTLOCK, 1'b0);
    check({tag, "_bus_idle"}, BUS_IDLE, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    HRESET  = 1'b1;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = NS;
    HREADY  = 1'b1;
    #1;
    check_reset_outputs("sync_reset");
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  // Assert reset between edges and observe outputs clear with no edge.
  task automatic async_reset_check(input string tag);
    @(posedge HCLK);
    #3;
    HRESET = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge HCLK);
    HBUSREQ = '0;
    HLOCK   = '0;
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  // Monitor: invariants every cycle, then scoreboard compare when queued.
  always @(posedge HCLK) begin
    #1;
    check("bus_idle_vs_grant", BUS_IDLE, (HGRANT == 8'h00));
    check("grant_popcount_gt1", ($countones(HGRANT) > 1), 1'b0);
    if (HGRANT != 8'h00) check("master_vs_grant", HGRANT, 8'h01 << HMASTER);
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("grant", HGRANT, mon_e.grant);
      check("master", HMASTER, mon_e.master);
      check("mastlock", HMASTLOCK, mon_e.mlock);
      check("bus_idle", BUS_IDLE, (mon_e.grant == 8'h00));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: first grant one edge after reset release; async reset mid-ownership.
    do_reset();
    st(8'h01, 8'h01, 3'd0);
    st(8'h01, 8'h01, 3'd0);
    async_reset_check("async_reset_m0");

    // 2: m2 wins from pointer 7, drops, dead cycle keeps HMASTER=2, then m5.
    do_reset();
    st(8'h24, 8'h04, 3'd2);
    st(8'h20, 8'h00, 3'd2);
    st(8'h20, 8'h20, 3'd5);
    st(8'h00, 8'h00, 3'd5);
    st(8'h00, 8'h00, 3'd5);

    // 3: quantum expiry hands m0 over to m3; m0 returns after m3 releases.
    do_reset();
    st(8'h01, 8'h01, 3'd0);
    for (int i = 0; i < 4; i++) st(8'h09, 8'h01, 3'd0);
    st(8'h09, 8'h00, 3'd0);
    st(8'h09, 8'h08, 3'd3);
    st(8'h09, 8'h08, 3'd3);
    st(8'h01, 8'h00, 3'd3);
    st(8'h01, 8'h01, 3'd0);
    st(8'h00, 8'h00, 3'd0);
    st(8'h00, 8'h00, 3'd0);

    // 4: locked m0 overstays the quantum until HLOCK[0] falls.
    do_reset();
    step(8'h01, 8'h01, NS, 1'b1, 8'h01, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(8'h09, 8'h01, NS, 1'b1, 8'h01, 3'd0, 1'b1);
    step(8'h09, 8'h00, NS, 1'b1, 8'h00, 3'd0, 1'b0);
    step(8'h09, 8'h00, NS, 1'b1, 8'h08, 3'd3, 1'b0);
    st(8'h00, 8'h00, 3'd3);
    st(8'h00, 8'h00, 3'd3);

    // 4b: quantum expires during SEQ; lock raised at the boundary blocks release.
    do_reset();
    st(8'h01, 8'h01, 3'd0);
    for (int i = 0; i < 5; i++) step(8'h09, 8'h00, SQ, 1'b1, 8'h01, 3'd0, 1'b0);
    step(8'h09, 8'h01, NS, 1'b1, 8'h01, 3'd0, 1'b1);
    step(8'h09, 8'h00, NS, 1'b1, 8'h00, 3'd0, 1'b0);
    st(8'h09, 8'h08, 3'd3);
    st(8'h00, 8'h00, 3'd3);

    // 5: m1 held through SEQ and wait states, released on IDLE with HREADY.
    do_reset();
    st(8'h02, 8'h02, 3'd1);
    step(8'h02, 8'h00, SQ, 1'b1, 8'h02, 3'd1, 1'b0);
    step(8'h00, 8'h00, SQ, 1'b1, 8'h02, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, SQ, 1'b0, 8'h02, 3'd1, 1'b0);
    step(8'h00, 8'h00, ID, 1'b1, 8'h00, 3'd1, 1'b0);
    // m4 wins over m1 (pointer at 1); wait states must not advance the quantum.
    st(8'h12, 8'h10, 3'd4);
    for (int i = 0; i < 6; i++) step(8'h12, 8'h00, NS, 1'b0, 8'h10, 3'd4, 1'b0);
    for (int i = 0; i < 4; i++) st(8'h12, 8'h10, 3'd4);
    st(8'h12, 8'h00, 3'd4);
    st(8'h12, 8'h02, 3'd1);
    async_reset_check("async_reset_m1");

    // 6: all masters requesting: rotation 0..7,0 with one dead cycle each.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 5; j++) st(8'hFF, 8'h01 << (k % 8), 3'(k % 8));
      st(8'hFF, 8'h00, 3'(k % 8));
    end
    st(8'h00, 8'h00, 3'd0);

    @(negedge HCLK);
    @(negedge HCLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
